// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, flag layout and reset flag value.
// Imported by the flag unit and its save stack.
package cpu_pkg;

    localparam int FLAG_W = 5;

    localparam int FLAG_N = 4;
    localparam int FLAG_Z = 3;
    localparam int FLAG_P = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef struct packed {
        logic n;
        logic z;
        logic p;
        logic c;
        logic v;
    } flags_t;

    localparam flags_t FLAGS_RST = 5'b01000;

    localparam logic [3:0] OP_LUI  = 4'b0011;
    localparam logic [3:0] OP_CPI  = 4'b0111;
    localparam logic [3:0] OP_ADDI = 4'b0001;
    localparam logic [3:0] OP_BRA  = 4'b1101;

    function automatic logic op_force0(input logic [3:0] op);
        return (op == OP_LUI) || (op == OP_CPI);
    endfunction

    function automatic logic op_force1(input logic [3:0] op);
        return (op == OP_ADDI) || (op == OP_BRA);
    endfunction

endpackage

// File: rtl/flag_stack.sv
// LIFO save stack for the flag register.
// Guards itself against overflow and underflow.
module flag_stack
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push,
    input  logic   pop,
    input  flags_t din,
    output flags_t dout,
    output logic   full,
    output logic   empty
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0] count;
    logic [CW-1:0] top;
    logic          wr;
    logic          rd;
    flags_t        mem [DEPTH];

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign top   = count - 1'b1;
    assign wr    = push && !pop && !full;
    assign rd    = pop && !push && !empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (wr) begin
            count <= count + 1'b1;
        end else if (rd) begin
            count <= count - 1'b1;
        end
    end

    // Contents are not reset; count alone defines validity.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (rst_n && wr && (count == CW'(i))) begin
                mem[i] <= din;
            end
        end
    end

    always_comb begin
        dout = FLAGS_RST;
        for (int i = 0; i < DEPTH; i++) begin
            if (!empty && (top == CW'(i))) begin
                dout = mem[i];
            end
        end
    end

endmodule

// File: rtl/flag_unit.sv
// Condition flag register with branch-condition evaluation
// and a save/restore stack.
module flag_unit
    import cpu_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int STACK_DEPTH = 4,
    parameter int BYPASS      = 1
) (
    input  logic             CLK,
    input  logic             Reset_n,
    input  logic [WIDTH-1:0] ALUOut,
    input  logic             CarryIn,
    input  logic             OvfIn,
    input  logic             FU,
    input  logic [2:0]       CC,
    input  logic [1:0]       CCX,
    input  logic [3:0]       Op,
    input  logic             Push,
    input  logic             Pop,
    output logic             Perform,
    output logic [4:0]       Flags,
    output logic             Full,
    output logic             Empty,
    output logic             StkErr
);

    flags_t     flags_q;
    flags_t     new_flags;
    flags_t     eff;
    flags_t     stk_top;
    logic [2:0] nzp;
    logic       stk_full;
    logic       stk_empty;
    logic       do_pop;
    logic       load_new;
    logic       err_evt;
    logic       match;

    always_comb begin
        if (ALUOut[WIDTH-1]) begin
            nzp = 3'b100;
        end else if (ALUOut == '0) begin
            nzp = 3'b010;
        end else begin
            nzp = 3'b001;
        end
    end

    assign new_flags = {nzp, CarryIn, OvfIn};

    // Any asserted Pop, legal or not, suppresses the flag update.
    assign load_new = FU && !Pop;
    assign do_pop   = Pop && !Push && !stk_empty;

    assign err_evt = (Push && Pop)
                   || (Push && !Pop && stk_full)
                   || (Pop && !Push && stk_empty);

    flag_stack #(
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk   (CLK),
        .rst_n (Reset_n),
        .push  (Push && !Pop),
        .pop   (Pop && !Push),
        .din   (flags_q),
        .dout  (stk_top),
        .full  (stk_full),
        .empty (stk_empty)
    );

    always_ff @(posedge CLK) begin
        if (!Reset_n) begin
            flags_q <= FLAGS_RST;
        end else if (do_pop) begin
            flags_q <= stk_top;
        end else if (load_new) begin
            flags_q <= new_flags;
        end
    end

    always_ff @(posedge CLK) begin
        if (!Reset_n) begin
            StkErr <= 1'b0;
        end else if (err_evt) begin
            StkErr <= 1'b1;
        end
    end

    assign eff = ((BYPASS != 0) && load_new) ? new_flags : flags_q;

    assign match = |(CC & {eff.n, eff.z, eff.p})
                 | |(CCX & {eff.c, eff.v})
                 | (CC == 3'b111);

    always_comb begin
        if (op_force0(Op)) begin
            Perform = 1'b0;
        end else if (op_force1(Op)) begin
            Perform = 1'b1;
        end else begin
            Perform = match;
        end
    end

    assign Flags = flags_q;
    assign Full  = stk_full;
    assign Empty = stk_empty;

endmodule

// File: tb/tb_flag_unit.sv
// Scoreboard bench for flag_unit: bypass and non-bypass instances
// share stimulus; a negedge monitor drains expected values.
module tb_flag_unit;

    logic        CLK;
    logic        Reset_n;
    logic [15:0] ALUOut;
    logic        CarryIn;
    logic        OvfIn;
    logic        FU;
    logic [2:0]  CC;
    logic [1:0]  CCX;
    logic [3:0]  Op;
    logic        Push;
    logic        Pop;

    logic        Perform, Full, Empty, StkErr;
    logic [4:0]  Flags;
    logic        Perform0, Full0, Empty0, StkErr0;
    logic [4:0]  Flags0;

    flag_unit #(.WIDTH(16), .STACK_DEPTH(4), .BYPASS(1)) dut (
        .CLK(CLK), .Reset_n(Reset_n), .ALUOut(ALUOut),
        .CarryIn(CarryIn), .OvfIn(OvfIn), .FU(FU), .CC(CC),
        .CCX(CCX), .Op(Op), .Push(Push), .Pop(Pop),
        .Perform(Perform), .Flags(Flags), .Full(Full),
        .Empty(Empty), .StkErr(StkErr)
    );

    flag_unit #(.WIDTH(16), .STACK_DEPTH(4), .BYPASS(0)) dut0 (
        .CLK(CLK), .Reset_n(Reset_n), .ALUOut(ALUOut),
        .CarryIn(CarryIn), .OvfIn(OvfIn), .FU(FU), .CC(CC),
        .CCX(CCX), .Op(Op), .Push(Push), .Pop(Pop),
        .Perform(Perform0), .Flags(Flags0), .Full(Full0),
        .Empty(Empty0), .StkErr(StkErr0)
    );

    localparam int FL  = 0;
    localparam int PF  = 1;
    localparam int FUL = 2;
    localparam int EMP = 3;
    localparam int ERR = 4;
    localparam int PF0 = 5;
    localparam int FL0 = 6;

    typedef struct {
        int         cyc;
        int         sel;
        logic [4:0] exp;
        string      name;
    } chk_t;

    chk_t q[$];
    int   cnt  = 0;
    int   vecs = 0;
    int   errs = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cnt <= cnt + 1;

    function automatic logic [4:0] pick(input int s);
        case (s)
            FL:      return Flags;
            PF:      return {4'b0, Perform};
            FUL:     return {4'b0, Full};
            EMP:     return {4'b0, Empty};
            ERR:     return {4'b0, StkErr};
            PF0:     return {4'b0, Perform0};
            FL0:     return Flags0;
            default: return 5'bxxxxx;
        endcase
    endfunction

    always @(negedge CLK) begin
        chk_t       c;
        logic [4:0] act;
        while (q.size() > 0 && q[0].cyc <= cnt) begin
            c   = q.pop_front();
            act = pick(c.sel);
            vecs++;
            if (c.cyc != cnt || act !== c.exp) begin
                errs++;
                $display("FAIL %s: got %b expected %b (cycle %0d/%0d)",
                         c.name, act, c.exp, cnt, c.cyc);
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic exp(input int s, input logic [4:0] v, input string n);
        q.push_back('{cyc: cnt, sel: s, exp: v, name: n});
    endtask

    initial begin
        Reset_n = 1'b0; ALUOut = '0; CarryIn = 1'b0; OvfIn = 1'b0;
        FU = 1'b0; CC = '0; CCX = '0; Op = '0; Push = 1'b0; Pop = 1'b0;

        step();
        Reset_n = 1'b1; CC = 3'b010;
        exp(FL, 5'b01000, "rst_flags");
        exp(EMP, 5'd1, "rst_empty");
        exp(FUL, 5'd0, "rst_full");
        exp(ERR, 5'd0, "rst_err");
        exp(PF, 5'd1, "rst_perform_z");

        step();
        FU = 1'b1; ALUOut = 16'h8000; CC = 3'b100;
        exp(PF, 5'd1, "bypass_same_cycle");
        exp(PF0, 5'd0, "nobypass_same_cycle");

        step();
        FU = 1'b0;
        exp(FL, 5'b10000, "update_flags");
        exp(FL0, 5'b10000, "update_flags_nb");
        exp(PF0, 5'd1, "nobypass_next_cycle");

        step();
        CC = 3'b111; Op = 4'b0011;
        exp(PF, 5'd0, "lui_force0");
        step();
        Op = 4'b0111;
        exp(PF, 5'd0, "cpi_force0");
        step();
        CC = 3'b000; Op = 4'b1101;
        exp(PF, 5'd1, "op1101_force1");
        step();
        Op = 4'b0001;
        exp(PF, 5'd1, "addi_force1");
        step();
        Op = 4'b0000; CCX = 2'b10;
        exp(PF, 5'd0, "ccx_c_clear");
        step();
        CCX = 2'b00; CC = 3'b011;
        exp(PF, 5'd0, "cc_no_match");

        step();
        FU = 1'b1; ALUOut = 16'h0001;
        step();
        FU = 1'b0;
        exp(FL, 5'b00100, "set_p");
        Push = 1'b1;
        step();
        Push = 1'b0; FU = 1'b1; ALUOut = 16'h0000;
        exp(EMP, 5'd0, "push_not_empty");
        step();
        FU = 1'b0;
        exp(FL, 5'b01000, "fu_after_push");
        Pop = 1'b1;
        step();
        Pop = 1'b0;
        exp(FL, 5'b00100, "pop_restore");
        exp(EMP, 5'd1, "pop_empty");
        exp(ERR, 5'd0, "pop_no_err");

        Push = 1'b1; FU = 1'b1; ALUOut = 16'h8000; CarryIn = 1'b1; OvfIn = 1'b0;
        step();
        exp(FL, 5'b10010, "push_fu_1");
        ALUOut = 16'h0000; CarryIn = 1'b0; OvfIn = 1'b1;
        step();
        ALUOut = 16'h0005; CarryIn = 1'b1; OvfIn = 1'b1;
        exp(FUL, 5'd0, "not_full_at2");
        step();
        FU = 1'b0;
        step();
        exp(FUL, 5'd1, "full_after4");
        exp(ERR, 5'd0, "no_err_at4");
        exp(FL, 5'b00111, "flags_at4");
        FU = 1'b1; ALUOut = 16'h8000; CarryIn = 1'b0; OvfIn = 1'b1;
        step();
        Push = 1'b0; FU = 1'b0; CC = 3'b000; CCX = 2'b01;
        exp(FL, 5'b10001, "push_full_fu");
        exp(ERR, 5'd1, "push_full_err");
        exp(FUL, 5'd1, "push_full_full");
        exp(PF, 5'd1, "ccx_v_set");

        step();
        CCX = 2'b00; Pop = 1'b1;
        step();
        exp(FL, 5'b00111, "pop1");
        exp(FUL, 5'd0, "pop1_not_full");
        step();
        exp(FL, 5'b01001, "pop2");
        step();
        exp(FL, 5'b10010, "pop3");
        step();
        Pop = 1'b0;
        exp(FL, 5'b00100, "pop4");
        exp(EMP, 5'd1, "empty_after4");

        Reset_n = 1'b0;
        step();
        Reset_n = 1'b1;
        exp(ERR, 5'd0, "rst_clears_err");
        exp(FL, 5'b01000, "rst2_flags");
        Push = 1'b1;
        step();
        Pop = 1'b1; FU = 1'b1; ALUOut = 16'h0001;
        step();
        Push = 1'b0; Pop = 1'b0; FU = 1'b0;
        exp(FL, 5'b01000, "conflict_flags");
        exp(EMP, 5'd0, "conflict_count");
        exp(ERR, 5'd1, "conflict_err");
        Pop = 1'b1;
        step();
        Pop = 1'b0;
        exp(FL, 5'b01000, "pop_after_conflict");
        exp(EMP, 5'd1, "empty_after_conflict");

        Push = 1'b1;
        step();
        Push = 1'b0; Reset_n = 1'b0;
        step();
        Reset_n = 1'b1;
        exp(EMP, 5'd1, "rst_abandons_stack");
        Pop = 1'b1; FU = 1'b1; ALUOut = 16'h8000; CC = 3'b100;
        exp(PF, 5'd0, "pop_blocks_bypass");
        step();
        Pop = 1'b0; FU = 1'b0;
        exp(FL, 5'b01000, "pop_empty_flags");
        exp(ERR, 5'd1, "pop_empty_err");
        exp(EMP, 5'd1, "pop_empty_empty");

        step();
        step();
        if (q.size() != 0) begin
            errs++;
            $display("FAIL drain: got %0d pending checks expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/flag_unit.md
FLAG_UNIT -- requirements
Module: flag_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning ALU result width in bits (≥2).
REQ-002 SHALL have parameter STACK_DEPTH, default 4, meaning flag save-stack entries (≥1).
REQ-003 SHALL have parameter BYPASS, default 1, meaning Perform sees same-cycle flag update when 1.
REQ-004 SHALL have ports: CLK  input  1  system clock, sole clock.
REQ-005 SHALL have ports: Reset_n  input  1  synchronous active-low reset.
REQ-006 SHALL have ports: ALUOut  input  WIDTH  ALU result.
REQ-007 SHALL have ports: CarryIn  input  1  ALU carry-out; OvfIn  input  1  ALU signed overflow.
REQ-008 SHALL have ports: FU  input  1  flag-update enable; CC  input  3  condition mask {N,Z,P}.
REQ-009 SHALL have ports: CCX  input  2  extended mask {C,V}; Op  input  4  current opcode.
REQ-010 SHALL have ports: Push  input  1  save flags; Pop  input  1  restore flags.
REQ-011 SHALL have ports: Perform  output  1  condition true; Flags  output  5  {N,Z,P,C,V} register.
REQ-012 SHALL have ports: Full, Empty  output  1 each  stack status; StkErr  output  1  sticky stack error.
REQ-013 SHALL use one clock, CLK; reset Reset_n is synchronous and active-low.

Function
REQ-014 SHALL compute next NZP from ALUOut: MSB=1 -> 100; else all-zero -> 010; else 001 (exactly one hot).
REQ-015 SHALL load Flags <= {nextNZP, CarryIn, OvfIn} on rising CLK when FU=1 and Pop=0; else hold.
REQ-016 SHALL form effective flags E = (BYPASS && FU && !Pop) ? newly computed flags : Flags register.
REQ-017 SHALL set match = |(CC & E.NZP) | |(CCX & E.CV) | (CC==3'b111).
REQ-018 SHALL drive Perform combinationally: Op 0011 or 0111 -> 0; else Op 0001 or 1101 -> 1; else match (force-0 checked first).
REQ-019 SHALL with BYPASS=0 give Perform from registered Flags only (one-cycle flag latency).
REQ-020 SHALL on Push (Pop=0, not Full) write current Flags register (pre-update value) to stack top, depth count +1, same edge.
REQ-021 SHALL on Pop (Push=0, not Empty) load Flags from stack top, count -1; Pop overrides FU that cycle.
REQ-022 SHALL ignore Push when Full and Pop when Empty: stack and Flags unchanged (FU still applies for Push-when-Full), StkErr <= 1.
REQ-023 SHALL treat Push=Pop=1 as error: stack and count unchanged, FU ignored, StkErr <= 1.
REQ-024 SHALL hold StkErr at 1 until reset.
REQ-025 SHALL assert Full when count==STACK_DEPTH, Empty when count==0, both from registered count.
REQ-026 SHALL size count as clog2(STACK_DEPTH+1) bits; no wrap-around permitted.

Reset
REQ-027 SHALL on Reset_n=0 at rising CLK set Flags=5'b01000 (Z), count=0, StkErr=0; Empty=1, Full=0.
REQ-028 SHALL give reset priority over FU, Push, Pop; stack contents need not be cleared.
REQ-029 SHALL abandon any in-progress Push/Pop on reset mid-sequence; first post-reset Pop is an error.

Structure
REQ-030 SHALL place opcode constants (LUI=0011, CPI=0111, ADDI=0001, 1101), flag bit indices, reset flag value in shared package cpu_pkg.
REQ-031 SHALL implement save stack as sub-module flag_stack (LIFO, 5-bit entries, STACK_DEPTH parameter, Full/Empty/count).
REQ-032 SHALL keep all state in CLK-edge processes; no latches.

Verification
REQ-033 SHALL test reset: Reset_n=0 one cycle -> Flags=01000, Empty=1, Full=0, StkErr=0; CC=010, Op=0000 -> Perform=1.
REQ-034 SHALL test update/bypass: FU=1, ALUOut=16'h8000, CC=100, Op=0000 -> Perform=1 same cycle (BYPASS=1), Flags=10000 next edge; BYPASS=0 -> Perform=0 that cycle, 1 next.
REQ-035 SHALL test Op overrides: CC=111, Op=0011 -> Perform=0; CC=000, Op=1101 -> Perform=1.
REQ-036 SHALL test stack: Flags=00100, Push; FU with ALUOut=0 (Flags=01000); Pop -> Flags=00100, Empty=1.
REQ-037 SHALL test overflow: 5 Pushes with STACK_DEPTH=4 -> Full=1 after 4th, 5th ignored, StkErr=1; 4 Pops return entries in reverse order.
REQ-038 SHALL test conflicts: Push=Pop=1 with FU=1, ALUOut=1 -> Flags, count unchanged, StkErr=1; Pop on Empty -> StkErr=1, Flags unchanged.
